ir_guard_ctrl: RTL and testbench

Scheduler and filter for the knight's IR line sensors. It duty-cycles the IR emitters (IR_en), samples the active-low left, right and center sensors only at the end of each emitter-on window, and debounces them into clean guardrail levels and single-cycle rise pulses. It also counts center-line crossings against a per-move target and signals move completion. It sits between the top-level IR pins and cmd_proc, which starts moves and consumes lftIR, rghtIR, cntrIR and move_done.

---
 rtl/ir_guard_ctrl.sv | 140 ++++++++++++++
 tb/tb_ir_guard_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ir_guard_ctrl.sv
// ir_guard_ctrl: duty-cycles the IR emitters, debounces the three line sensors at
// the end of each emitter-on window, and counts center-line crossings per move.
module ir_guard_ctrl #(
    parameter bit FAST_SIM   = 1'b1,
    parameter int DB_SAMPLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ir_enable,
    input  logic       move_start,
    input  logic [2:0] num_sqrs,
    input  logic       move_abort,
    input  logic       lftIR_n,
    input  logic       rghtIR_n,
    input  logic       cntrIR_n,
    output logic       IR_en,
    output logic       lftIR,
    output logic       rghtIR,
    output logic       cntrIR,
    output logic       lft_rise,
    output logic       rght_rise,
    output logic       cntr_rise,
    output logic       busy,
    output logic       move_done,
    output logic [3:0] xings,
    output logic [1:0] dbg_state_o
);
    localparam int              PERIOD  = FAST_SIM ? 512 : 4096;
    localparam int              PW      = $clog2(PERIOD);
    localparam logic [PW-1:0]   ON_LAST = PW'(PERIOD / 4 - 1);
    localparam logic [2:0]      DB_TH   = 3'(DB_SAMPLES);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_SAMPLE, S_OFF} state_t;

    // Channel vectors are ordered {lft, rght, cntr}.
    logic [2:0]      meta_q, sync_q, s_raw;
    logic [PW-1:0]   ph_q, ph_d;
    state_t          state_q, state_d;
    logic [2:0]      lvl_q, lvl_d, rise_q, rise_d;
    logic [2:0][2:0] cnt_q, cnt_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic [3:0]      xings_q, xings_d, xings_inc, target_q, target_d;
    logic            active;

    assign active = ir_enable | busy_q;
    assign s_raw  = ~sync_q;
    assign ph_d   = active ? ph_q + PW'(1) : '0;

    always_comb begin
        state_d = S_IDLE;
        if (active) begin
            if (ph_q == ON_LAST)     state_d = S_SAMPLE;
            else if (ph_q < ON_LAST) state_d = S_ON;
            else                     state_d = S_OFF;
        end
    end

    // A sample only moves the level after DB_SAMPLES consecutive disagreements.
    always_comb begin
        lvl_d  = lvl_q;
        cnt_d  = cnt_q;
        rise_d = '0;
        if (!active) begin
            lvl_d = '0;
            cnt_d = '0;
        end else if (state_q == S_SAMPLE) begin
            for (int i = 0; i < 3; i++) begin
                if (s_raw[i] == lvl_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] + 3'd1 == DB_TH) begin
                    lvl_d[i]  = s_raw[i];
                    cnt_d[i]  = '0;
                    rise_d[i] = s_raw[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 3'd1;
                end
            end
        end
    end

    // Pulses (rises, move_done) are single-cycle with no back-pressure; a
    // completing crossing beats an abort, a new start beats both.
    always_comb begin
        xings_inc = (xings_q == 4'hF) ? 4'hF : xings_q + 4'd1;
        busy_d    = busy_q;
        xings_d   = xings_q;
        target_d  = target_q;
        done_d    = 1'b0;
        if (move_start) begin
            target_d = {num_sqrs, 1'b0};
            xings_d  = '0;
            busy_d   = (num_sqrs != 3'd0);
            done_d   = (num_sqrs == 3'd0);
        end else if (busy_q && rise_q[0] && xings_inc == target_q) begin
            xings_d = xings_inc;
            done_d  = 1'b1;
            busy_d  = 1'b0;
        end else if (move_abort) begin
            busy_d = 1'b0;
        end else if (busy_q && rise_q[0]) begin
            xings_d = xings_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q   <= '1;
            sync_q   <= '1;
            ph_q     <= '0;
            state_q  <= S_IDLE;
            lvl_q    <= '0;
            cnt_q    <= '0;
            rise_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            xings_q  <= '0;
            target_q <= '0;
        end else begin
            meta_q   <= {lftIR_n, rghtIR_n, cntrIR_n};
            sync_q   <= meta_q;
            ph_q     <= ph_d;
            state_q  <= state_d;
            lvl_q    <= lvl_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            xings_q  <= xings_d;
            target_q <= target_d;
        end
    end

    assign IR_en                            = (state_q == S_ON) || (state_q == S_SAMPLE);
    assign {lftIR, rghtIR, cntrIR}          = lvl_q;
    assign {lft_rise, rght_rise, cntr_rise} = rise_q;
    assign busy                             = busy_q;
    assign move_done                        = done_q;
    assign xings                            = xings_q;
    assign dbg_state_o                      = state_q;
endmodule

// File: tb/tb_ir_guard_ctrl.sv
// Directed bench for ir_guard_ctrl: emitter schedule, debounce, crossing counter,
// abort, enable drop and reset mid-move.
module tb_ir_guard_ctrl;
  localparam int PER = 512;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ir_enable, move_start, move_abort;
  logic [2:0] num_sqrs;
  logic       lftIR_n, rghtIR_n, cntrIR_n;
  logic       IR_en, lftIR, rghtIR, cntrIR, lft_rise, rght_rise, cntr_rise;
  logic       busy, move_done;
  logic [3:0] xings;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0, cntr_rise_seen = 0, lft_rise_seen = 0, rght_rise_seen = 0;

  ir_guard_ctrl #(.FAST_SIM(1'b1), .DB_SAMPLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ir_enable(ir_enable), .move_start(move_start),
    .num_sqrs(num_sqrs), .move_abort(move_abort), .lftIR_n(lftIR_n),
    .rghtIR_n(rghtIR_n), .cntrIR_n(cntrIR_n), .IR_en(IR_en), .lftIR(lftIR),
    .rghtIR(rghtIR), .cntrIR(cntrIR), .lft_rise(lft_rise), .rght_rise(rght_rise),
    .cntr_rise(cntr_rise), .busy(busy), .move_done(move_done), .xings(xings),
    .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // pulse monitors, sampled away from the active edge
  always @(negedge clk) begin
    if (move_done) done_seen++;
    if (cntr_rise) cntr_rise_seen++;
    if (lft_rise)  lft_rise_seen++;
    if (rght_rise) rght_rise_seen++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_cntr_rise(input int max_cyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      step();
      if (cntr_rise) found = 1'b1;
    end
  endtask

  task automatic pulse_start(input logic [2:0] n);
    move_start = 1'b1;
    num_sqrs   = n;
    step();
    move_start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ir_en"}, IR_en, 0);
    check_eq({tag, "_levels"}, {lftIR, rghtIR, cntrIR}, 0);
    check_eq({tag, "_rises"}, {lft_rise, rght_rise, cntr_rise}, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_move_done"}, move_done, 0);
    check_eq({tag, "_xings"}, xings, 0);
  endtask

  initial begin
    bit found, prev;
    int bad, low_cnt, d0, r0, l0, g0;

    rst_n = 1'b0; ir_enable = 1'b0; move_start = 1'b0; move_abort = 1'b0;
    num_sqrs = 3'd0; lftIR_n = 1'b1; rghtIR_n = 1'b1; cntrIR_n = 1'b1;
    run(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // emitter schedule: 0 this cycle, then 128 high / 384 low every 512
    ir_enable = 1'b1;
    check_eq("ir_en_first_cycle", IR_en, 0);
    bad = 0;
    for (int k = 1; k <= 3 * PER; k++) begin
      step();
      if (IR_en !== (((k - 1) % PER) < 128)) bad++;
      if (k == 1)   check_eq("ir_en_k1", IR_en, 1);
      if (k == 128) check_eq("ir_en_k128", IR_en, 1);
      if (k == 129) check_eq("ir_en_k129", IR_en, 0);
      if (k == 513) check_eq("ir_en_k513", IR_en, 1);
    end
    check_eq("ir_en_pattern_bad_cycles", bad, 0);
    check_eq("idle_levels_low", {lftIR, rghtIR, cntrIR}, 0);

    // center held low for several periods: level high, exactly one rise
    r0 = cntr_rise_seen;
    cntrIR_n = 1'b0;
    run(3 * PER);
    check_eq("cntr_level_high", cntrIR, 1);
    check_eq("cntr_single_rise", cntr_rise_seen - r0, 1);
    check_eq("lft_untouched", lftIR, 0);

    // glitch that spans exactly one SAMPLE: level must not move
    found = 1'b0;
    prev  = IR_en;
    for (int i = 0; i < 2 * PER && !found; i++) begin
      step();
      if (prev && !IR_en) found = 1'b1;
      prev = IR_en;
    end
    check_eq("find_window_end", found, 1);
    r0 = cntr_rise_seen;
    low_cnt = 0;
    for (int i = 0; i < 200; i++) begin step(); if (!cntrIR) low_cnt++; end
    cntrIR_n = 1'b1;
    for (int i = 0; i < PER; i++) begin step(); if (!cntrIR) low_cnt++; end
    cntrIR_n = 1'b0;
    for (int i = 0; i < 3 * PER; i++) begin step(); if (!cntrIR) low_cnt++; end
    check_eq("glitch_level_held", low_cnt, 0);
    check_eq("glitch_no_rise", cntr_rise_seen - r0, 0);

    // two-square move: four crossings, done on the fourth
    cntrIR_n = 1'b1;
    run(3 * PER);
    check_eq("cntr_level_fell", cntrIR, 0);
    d0 = done_seen;
    pulse_start(3'd2);
    check_eq("move2_busy", busy, 1);
    check_eq("move2_xings0", xings, 0);
    for (int j = 1; j <= 4; j++) begin
      cntrIR_n = 1'b0;
      wait_cntr_rise(3 * PER, found);
      check_eq($sformatf("move2_rise%0d_seen", j), found, 1);
      check_eq($sformatf("move2_xings_pre%0d", j), xings, j - 1);
      step();
      check_eq($sformatf("move2_xings%0d", j), xings, j);
      check_eq($sformatf("move2_done%0d", j), move_done, (j == 4));
      check_eq($sformatf("move2_busy%0d", j), busy, (j != 4));
      cntrIR_n = 1'b1;
      run(3 * PER);
    end
    check_eq("move2_done_count", done_seen - d0, 1);
    check_eq("move2_xings_hold", xings, 4);

    // zero-square move: done next cycle, never busy
    d0 = done_seen;
    pulse_start(3'd0);
    check_eq("move0_done", move_done, 1);
    check_eq("move0_busy", busy, 0);
    check_eq("move0_xings", xings, 0);
    step();
    check_eq("move0_done_one_cycle", move_done, 0);
    check_eq("move0_busy_after", busy, 0);
    check_eq("move0_done_count", done_seen - d0, 1);

    // abort mid-move: busy drops, no done, later crossings ignored
    d0 = done_seen;
    pulse_start(3'd3);
    check_eq("abort_busy_start", busy, 1);
    cntrIR_n = 1'b0;
    wait_cntr_rise(3 * PER, found);
    check_eq("abort_rise1_seen", found, 1);
    step();
    check_eq("abort_xings1", xings, 1);
    move_abort = 1'b1;
    step();
    move_abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_no_done", move_done, 0);
    check_eq("abort_xings_hold", xings, 1);
    cntrIR_n = 1'b1;
    run(3 * PER);
    cntrIR_n = 1'b0;
    wait_cntr_rise(3 * PER, found);
    check_eq("abort_rise2_seen", found, 1);
    run(4);
    check_eq("abort_xings_frozen", xings, 1);
    check_eq("abort_done_count", done_seen - d0, 0);

    // left/right channels, then drop ir_enable while the emitter is on
    l0 = lft_rise_seen;
    g0 = rght_rise_seen;
    lftIR_n = 1'b0;
    rghtIR_n = 1'b0;
    run(3 * PER);
    check_eq("lr_levels", {lftIR, rghtIR, cntrIR}, 3'b111);
    check_eq("lft_single_rise", lft_rise_seen - l0, 1);
    check_eq("rght_single_rise", rght_rise_seen - g0, 1);
    found = 1'b0;
    for (int i = 0; i < PER && !found; i++) begin
      step();
      if (IR_en) found = 1'b1;
    end
    check_eq("find_ir_en_high", found, 1);
    ir_enable = 1'b0;
    step();
    check_eq("drop_ir_en", IR_en, 0);
    check_eq("drop_levels_cleared", {lftIR, rghtIR, cntrIR}, 0);
    run(PER);
    check_eq("drop_stays_idle", IR_en, 0);

    // reset in the middle of a move
    d0 = done_seen;
    ir_enable = 1'b1;
    pulse_start(3'd5);
    check_eq("rst_move_busy", busy, 1);
    wait_cntr_rise(3 * PER, found);
    check_eq("rst_move_rise_seen", found, 1);
    step();
    check_eq("rst_move_xings1", xings, 1);
    rst_n = 1'b0;
    step();
    check_reset_outputs("mid_move_reset");
    rst_n = 1'b1;
    run(2);
    check_eq("rst_no_done", done_seen - d0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
